timer_slot_scheduler: RTL and testbench

- Shares one N-bit loadable up-counter among M requesters. Each requester asks for a timed interval by supplying a start value.
- A round-robin arbiter grants one requester at a time and loads its start value into the counter. The counter runs to all-ones, then the scheduler returns a one-cycle ack to the owner.
- Sits between protocol FSMs that need timeouts and the single shared counter datapath.

---
 rtl/timer_slot_scheduler_pkg.sv | 17 +
 rtl/timer_slot_scheduler_rr_arbiter.sv | 30 +++
 rtl/timer_slot_scheduler.sv | 128 ++++++++++++
 tb/tb_timer_slot_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/timer_slot_scheduler_pkg.sv
// Shared types and default sizing for the timer slot scheduler.
// The optional prescaler is enabled by defining PRESCALE_EN.
package timer_slot_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TSS_N = 4;
  localparam int TSS_M = 4;
  localparam int TSS_PRE_W = 2;
  localparam logic [TSS_N-1:0] CNT_MAX = {TSS_N{1'b1}};
  localparam int ID_W = $clog2(TSS_M);

endpackage

// File: rtl/timer_slot_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, wrapping.
// Zero latency; no backpressure (the caller decides when the grant is taken).
module rr_arbiter #(
  parameter int M    = 4,
  parameter int ID_W = $clog2(M)
) (
  input  logic [M-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [M-1:0]    o_gnt,
  output logic [ID_W-1:0] o_idx
);

  always_comb begin
    logic found;
    int   j;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < M; k++) begin
      j = (int'(i_ptr) + k) % M;
      if (!found && i_req[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/timer_slot_scheduler.sv
// One shared N-bit up-counter time-sliced among M requesters; ack pulses when the owner's interval ends.
// Optional PRESCALE_EN slows the counter by 2^PRE_W; the owner dropping req aborts the run without ack.
module timer_slot_scheduler
  import timer_slot_scheduler_pkg::*;
#(
  parameter int N = TSS_N,
  parameter int M = TSS_M
`ifdef PRESCALE_EN
  ,
  parameter int PRE_W = TSS_PRE_W
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [M-1:0]         req,
  input  logic [M*N-1:0]       start_val,
  output logic [M-1:0]         ack,
  output logic                 busy,
  output logic [$clog2(M)-1:0] grant_id,
  output logic [N-1:0]         count
);

  localparam int GID_W = $clog2(M);
  localparam logic [N-1:0] CNT_ALL = {N{1'b1}};

  state_e           r_state, w_state_nxt;
  logic [N-1:0]     r_count, w_count_nxt;
  logic [GID_W-1:0] r_gid, w_gid_nxt;
  logic [GID_W-1:0] r_ptr, w_ptr_nxt;
  logic [M-1:0]     r_ack, w_ack_nxt;
  logic [M-1:0]     w_gnt;
  logic [GID_W-1:0] w_idx;
  logic [GID_W-1:0] w_ptr_inc;
  logic [N-1:0]     w_sv_sel;
  logic             w_pre_clr;
  logic             w_tick;

  rr_arbiter #(.M(M), .ID_W(GID_W)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_sv_sel = '0;
    for (int i = 0; i < M; i++) begin
      if (w_gnt[i]) w_sv_sel = w_sv_sel | start_val[i*N +: N];
    end
  end

  assign w_ptr_inc = (r_gid == GID_W'(M-1)) ? '0 : r_gid + 1'b1;

`ifdef PRESCALE_EN
  logic [PRE_W-1:0] r_pre;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_pre <= '0;
    else if (w_pre_clr)       r_pre <= '0;
    else if (r_state == RUN)  r_pre <= r_pre + 1'b1;
  end

  assign w_tick = &r_pre;
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_gid_nxt   = r_gid;
    w_ptr_nxt   = r_ptr;
    w_ack_nxt   = '0;
    w_pre_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_gid_nxt   = w_idx;
          w_count_nxt = w_sv_sel;
          w_state_nxt = RUN;
          w_pre_clr   = 1'b1;
        end
      end
      RUN: begin
        // Abort takes priority over expiry: an owner that withdrew gets no ack.
        if (!req[r_gid]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_inc;
          w_pre_clr   = 1'b1;
        end else if (w_tick) begin
          if (r_count == CNT_ALL) begin
            w_state_nxt      = DONE;
            w_ack_nxt[r_gid] = 1'b1;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = w_ptr_inc;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_gid   <= w_gid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign ack      = r_ack;
  assign busy     = (r_state != IDLE);
  assign grant_id = r_gid;
  assign count    = r_count;

endmodule

// File: tb/tb_timer_slot_scheduler.sv
// Directed bench for timer_slot_scheduler: reset, intervals, boundaries, round-robin order, abort.
module tb_timer_slot_scheduler;

  localparam int N = 4;
  localparam int M = 4;
`ifdef PRESCALE_EN
  localparam int SCALE = 4;
  localparam int ABORT_CNT = 5;
`else
  localparam int SCALE = 1;
  localparam int ABORT_CNT = 8;
`endif

  logic           clk;
  logic           reset_n;
  logic [M-1:0]   req;
  logic [M*N-1:0] start_val;
  logic [M-1:0]   ack;
  logic           busy;
  logic [1:0]     grant_id;
  logic [N-1:0]   count;

  int n_chk;
  int n_err;

  timer_slot_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .start_val (start_val),
    .ack       (ack),
    .busy      (busy),
    .grant_id  (grant_id),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts edges until ack is seen; -1 if the budget expires.
  task automatic wait_ack(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ack == '0 && n < limit);
    if (ack == '0) n = -1;
  endtask

  task automatic set_sv(input int idx, input int v);
    start_val[idx*N +: N] = N'(v);
  endtask

  initial begin
    int n;
    int seen;
    int rr_exp [6];
    n_chk = 0;
    n_err = 0;
    rr_exp = '{0, 1, 3, 0, 1, 3};
    reset_n = 1'b0;
    req = '0;
    start_val = '0;
    step(); step();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_gid", int'(grant_id), 0);
    reset_n = 1'b1;

    // Reset in the middle of a run
    req = 4'b0010;
    set_sv(1, 10);
    step();
    chk("mr_gid", int'(grant_id), 1);
    chk("mr_count", int'(count), 10);
    step(); step();
    reset_n = 1'b0;
    #1;
    chk("mr_async_count", int'(count), 0);
    chk("mr_async_busy", int'(busy), 0);
    chk("mr_async_ack", int'(ack), 0);
    req = '0;
    step();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack != '0) seen++;
    end
    chk("mr_no_ack", seen, 0);

    // Single request, start 12
    req = 4'b0100;
    set_sv(2, 12);
    step();
    chk("single_gid", int'(grant_id), 2);
    chk("single_cnt0", int'(count), 12);
    chk("single_busy", int'(busy), 1);
`ifdef PRESCALE_EN
    wait_ack(200, n);
    chk("single_lat", n, 4 * SCALE);
`else
    step(); chk("single_cnt1", int'(count), 13);
    step(); chk("single_cnt2", int'(count), 14);
    step(); chk("single_cnt3", int'(count), 15);
    chk("single_noack_early", int'(ack), 0);
    step();
`endif
    chk("single_ack", int'(ack), 4'b0100);
    chk("single_busy_done", int'(busy), 1);
    req = '0;
    step();
    chk("single_ack_width", int'(ack), 0);
    chk("single_busy_after", int'(busy), 0);

    // Boundary: start all-ones on requester 0
    req = 4'b0001;
    set_sv(0, 15);
    step();
    chk("max_gid", int'(grant_id), 0);
    wait_ack(200, n);
    chk("max_lat", n, 1 * SCALE);
    chk("max_ack", int'(ack), 4'b0001);
    req = '0;
    step();
    chk("max_ack_width", int'(ack), 0);

    // Boundary: start zero on requester 3
    req = 4'b1000;
    set_sv(3, 0);
    step();
    chk("zero_gid", int'(grant_id), 3);
    wait_ack(400, n);
    chk("zero_lat", n, 16 * SCALE);
    chk("zero_ack", int'(ack), 4'b1000);
    req = '0;
    step();

    // Round-robin with req held
    req = 4'b1011;
    for (int i = 0; i < M; i++) set_sv(i, 14);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rr_gid%0d", i), int'(grant_id), rr_exp[i]);
      wait_ack(200, n);
      chk($sformatf("rr_lat%0d", i), n, 2 * SCALE);
      chk($sformatf("rr_ack%0d", i), int'(ack), 1 << rr_exp[i]);
      step();
      chk($sformatf("rr_ackoff%0d", i), int'(ack), 0);
    end
    req = '0;
    step();

    // Abort: owner 0 withdraws, next pending above 0 is 2
    req = 4'b1101;
    set_sv(0, 5);
    set_sv(2, 14);
    step();
    chk("ab_gid", int'(grant_id), 0);
    step(); step(); step();
    req = 4'b1100;
    step();
    chk("ab_busy", int'(busy), 0);
    chk("ab_ack", int'(ack), 0);
    chk("ab_count_hold", int'(count), ABORT_CNT);
    step();
    chk("ab_next_gid", int'(grant_id), 2);
    wait_ack(200, n);
    chk("ab_next_ack", int'(ack), 4'b0100);
    req = '0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
